// File: rtl/sd_adc_cic.sv
// ---------------------------------------------------------------------------
// sd_adc_cic
//   Multi-channel sigma-delta ADC front end. For each channel it closes the
//   comparator/integrator feedback loop and decimates the 1-bit stream with a
//   CIC filter of ORDER stages and decimation ratio R = 2**LOG2R. All channels
//   share one decimation counter and commit their output words together.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous reset, active low, overrides everything
//   ce         modulator tick; filter state, fb and counter advance only here
//   sdin       comparator outputs, one bit per channel
//   fb         registered feedback to the analog integrators (~sdin)
//   dout       output words, channel c in [c*OW +: OW]
//   valid      dout holds an unread sample set
//   ready      consumer accepts dout when valid && ready
//   newsample  one-clk pulse on the ce tick that commits a new sample set
//   overrun    sticky: a sample set was overwritten before being accepted
//   ovr_clr    clears overrun (a new overrun in the same cycle wins)
//
// Handshake: dout/valid form a valid/ready source. valid rises on every
// commit and drops on valid && ready when no commit happens in that cycle.
// A commit always overwrites dout; if valid was high and ready low the
// previous set is lost and overrun is set. dout only changes on a commit.
// ---------------------------------------------------------------------------
module sd_adc_cic #(
    parameter int NCH   = 2,
    parameter int ORDER = 3,
    parameter int LOG2R = 6,
    parameter int OW    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [NCH-1:0]    sdin,
    output logic [NCH-1:0]    fb,
    output logic [NCH*OW-1:0] dout,
    output logic              valid,
    input  logic              ready,
    output logic              newsample,
    output logic              overrun,
    input  logic              ovr_clr
);

    // One guard bit above the full gain R**ORDER so that exact full scale
    // shows up as the top bit and can be saturated.
    localparam int W = ORDER * LOG2R + 1;

    logic [W-1:0]     integ [NCH][ORDER];
    logic [W-1:0]     dly   [NCH][ORDER];
    logic [W-1:0]     add_v [NCH][ORDER];
    logic [W-1:0]     sub_v [NCH][ORDER];
    logic [OW-1:0]    word  [NCH];
    logic [LOG2R-1:0] cnt;
    logic             commit;

    // Commit happens on the ce tick where the counter reads all ones.
    assign commit    = rst_n && ce && (&cnt);
    assign newsample = commit;

    // Integrator adders and comb subtractors, all modulo 2**W. The integrator
    // input is ~fb, i.e. the comparator bit of the previous tick.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < ORDER; k++) begin
                if (k == 0) begin
                    add_v[c][k] = {{(W-1){1'b0}}, ~fb[c]} + integ[c][k];
                end else begin
                    add_v[c][k] = add_v[c][k-1] + integ[c][k];
                end
            end
            for (int k = 0; k < ORDER; k++) begin
                if (k == 0) begin
                    sub_v[c][k] = add_v[c][ORDER-1] - dly[c][k];
                end else begin
                    sub_v[c][k] = sub_v[c][k-1] - dly[c][k];
                end
            end
            // Top bit set only at exact full scale: clamp to all ones.
            if (sub_v[c][ORDER-1][W-1]) begin
                word[c] = '1;
            end else begin
                word[c] = sub_v[c][ORDER-1][W-2 -: OW];
            end
        end
    end

    // Modulator feedback, integrators, decimation counter and comb delays.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb  <= '0;
            cnt <= '0;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ[c][k] <= '0;
                    dly[c][k]   <= '0;
                end
            end
        end else if (ce) begin
            fb  <= ~sdin;
            cnt <= cnt + LOG2R'(1);
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ[c][k] <= add_v[c][k];
                end
                if (commit) begin
                    dly[c][0] <= add_v[c][ORDER-1];
                    for (int k = 1; k < ORDER; k++) begin
                        dly[c][k] <= sub_v[c][k-1];
                    end
                end
            end
        end
    end

    // Output register and handshake; runs every clk regardless of ce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (commit) begin
                for (int c = 0; c < NCH; c++) begin
                    dout[c*OW +: OW] <= word[c];
                end
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (commit && valid && !ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_adc_cic.sv
`timescale 1ns/1ps
module tb_sd_adc_cic;

  // Two instances: default configuration (a) and the small one (b).
  localparam int NA = 2, OA = 3, LA = 6, OWA = 12, WA = 19, RA = 64;
  localparam int NB = 1, OB = 2, LB = 5, OWB = 10, WB = 11, RB = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n_a, ce_a, ready_a, ovr_clr_a;
  logic [1:0]      sdin_a;
  logic [1:0]      fb_a;
  logic [NA*OWA-1:0] dout_a;
  logic            valid_a, newsample_a, overrun_a;

  logic            rst_n_b, ce_b, ready_b, ovr_clr_b;
  logic [0:0]      sdin_b;
  logic [0:0]      fb_b;
  logic [NB*OWB-1:0] dout_b;
  logic            valid_b, newsample_b, overrun_b;

  sd_adc_cic #(.NCH(NA), .ORDER(OA), .LOG2R(LA), .OW(OWA)) u_a (
    .clk(clk), .rst_n(rst_n_a), .ce(ce_a), .sdin(sdin_a), .fb(fb_a),
    .dout(dout_a), .valid(valid_a), .ready(ready_a),
    .newsample(newsample_a), .overrun(overrun_a), .ovr_clr(ovr_clr_a)
  );

  sd_adc_cic #(.NCH(NB), .ORDER(OB), .LOG2R(LB), .OW(OWB)) u_b (
    .clk(clk), .rst_n(rst_n_b), .ce(ce_b), .sdin(sdin_b), .fb(fb_b),
    .dout(dout_b), .valid(valid_b), .ready(ready_b),
    .newsample(newsample_b), .overrun(overrun_b), .ovr_clr(ovr_clr_b)
  );

  // ---------------- scoreboard / reference model ----------------
  // Streams 0,1 = instance a channels, stream 2 = instance b channel.
  // The filter is modelled by its impulse response: the CIC output at a
  // commit tick is the convolution of the integrator-input bit stream with
  // the coefficients of ((1 - z^-R)/(1 - z^-1))^N, taken modulo 2^W.
  bit     xh [3][8192];
  int     nt [2];
  bit     last_in [3];
  bit     valid_m [2];
  bit     ovr_m [2];
  int     dexp [3];
  longint hh [2][1024];
  int     n_tests = 0;
  int     n_fail = 0;

  function automatic int cfg_n(int d);  return d ? OB : OA;   endfunction
  function automatic int cfg_r(int d);  return d ? RB : RA;   endfunction
  function automatic int cfg_w(int d);  return d ? WB : WA;   endfunction
  function automatic int cfg_ow(int d); return d ? OWB : OWA; endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic build_h(int d);
    longint tmp [1024];
    int len, r;
    r = cfg_r(d);
    for (int i = 0; i < 1024; i++) hh[d][i] = 0;
    hh[d][0] = 1;
    len = 1;
    repeat (cfg_n(d)) begin
      for (int i = 0; i < 1024; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int k = 0; k < r; k++) tmp[i+k] += hh[d][i];
      len += r - 1;
      for (int i = 0; i < len; i++) hh[d][i] = tmp[i];
    end
  endtask

  function automatic int cic_word(int s, int d);
    longint acc, mask;
    int t, len, w, ow;
    acc = 0;
    t   = nt[d] - 1;
    len = cfg_n(d) * (cfg_r(d) - 1) + 1;
    w   = cfg_w(d);
    ow  = cfg_ow(d);
    for (int j = 0; j < len; j++)
      if ((t - j) >= 0 && (t - j) < 8192)
        if (xh[s][t-j]) acc += hh[d][j];
    mask = (longint'(1) << w) - 1;
    acc  = acc & mask;
    if (((acc >> (w - 1)) & 1) == 1) return (1 << ow) - 1;
    return int'((acc >> (w - 1 - ow)) & ((longint'(1) << ow) - 1));
  endfunction

  task automatic model_step(int d, bit rst, bit ce, bit [1:0] sd, bit rdy, bit clr);
    int nch, s0, r;
    bit commit;
    nch = d ? NB : NA;
    s0  = d ? 2 : 0;
    r   = cfg_r(d);
    if (!rst) begin
      nt[d] = 0; valid_m[d] = 0; ovr_m[d] = 0;
      for (int c = 0; c < nch; c++) begin
        last_in[s0+c] = 1'b1;   // fb resets to 0, so the first input is 1
        dexp[s0+c] = 0;
      end
    end else begin
      commit = ce && ((nt[d] % r) == r - 1);
      if (ce) begin
        for (int c = 0; c < nch; c++) begin
          if (nt[d] < 8192) xh[s0+c][nt[d]] = last_in[s0+c];
          last_in[s0+c] = sd[c];
        end
        nt[d]++;
      end
      if (commit) begin
        if (valid_m[d] && !rdy) ovr_m[d] = 1'b1;
        else if (clr) ovr_m[d] = 1'b0;
        valid_m[d] = 1'b1;
        for (int c = 0; c < nch; c++) dexp[s0+c] = cic_word(s0 + c, d);
      end else begin
        if (valid_m[d] && rdy) valid_m[d] = 1'b0;
        if (clr) ovr_m[d] = 1'b0;
      end
    end
  endtask

  // Monitors: inputs change only on negedge, so they are stable at posedge.
  always @(posedge clk) begin
    model_step(0, rst_n_a, ce_a, sdin_a, ready_a, ovr_clr_a);
    #1;
    check_eq("a_fb", {30'd0, fb_a}, {30'd0, ~last_in[1], ~last_in[0]});
    check_eq("a_dout0", {20'd0, dout_a[11:0]}, dexp[0]);
    check_eq("a_dout1", {20'd0, dout_a[23:12]}, dexp[1]);
    check_eq("a_valid", {31'd0, valid_a}, {31'd0, valid_m[0]});
    check_eq("a_overrun", {31'd0, overrun_a}, {31'd0, ovr_m[0]});
    check_eq("a_newsample", {31'd0, newsample_a},
             {31'd0, rst_n_a && ce_a && ((nt[0] % RA) == RA - 1)});
  end

  always @(posedge clk) begin
    model_step(1, rst_n_b, ce_b, {1'b0, sdin_b}, ready_b, ovr_clr_b);
    #1;
    check_eq("b_fb", {31'd0, fb_b}, {31'd0, ~last_in[2]});
    check_eq("b_dout", {22'd0, dout_b}, dexp[2]);
    check_eq("b_valid", {31'd0, valid_b}, {31'd0, valid_m[1]});
    check_eq("b_overrun", {31'd0, overrun_b}, {31'd0, ovr_m[1]});
    check_eq("b_newsample", {31'd0, newsample_b},
             {31'd0, rst_n_b && ce_b && ((nt[1] % RB) == RB - 1)});
  end

  // ---------------- driver tasks ----------------
  function automatic bit pick(int m, bit t);
    case (m)
      0: return 1'b0;
      1: return 1'b1;
      2: return t;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // ce_every = 0 gives random ce. rdy_mode: 0 low, 1 high, 2 random (with
  // random ovr_clr), 3 high only on commit ticks.
  task automatic drive(int d, int ncyc, int ce_every, int m0, int m1, int rdy_mode);
    bit tog0, tog1, c, s0, s1, r, cl;
    int rr;
    tog0 = 1'b0; tog1 = 1'b0;
    rr = cfg_r(d);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      c  = (ce_every == 0) ? ($urandom_range(0, 1) == 1) : ((i % ce_every) == 0);
      s0 = pick(m0, tog0);
      s1 = pick(m1, tog1);
      if (c) begin tog0 = ~tog0; tog1 = ~tog1; end
      case (rdy_mode)
        0: r = 1'b0;
        1: r = 1'b1;
        2: r = ($urandom_range(0, 3) == 0);
        default: r = c && ((nt[d] % rr) == rr - 1);
      endcase
      cl = (rdy_mode == 2) && ($urandom_range(0, 7) == 0);
      if (d == 0) begin
        ce_a = c; sdin_a = {s1, s0}; ready_a = r; ovr_clr_a = cl;
      end else begin
        ce_b = c; sdin_b = s0; ready_b = r; ovr_clr_b = cl;
      end
    end
  endtask

  task automatic do_reset(int d);
    @(negedge clk);
    if (d == 0) begin rst_n_a = 0; ce_a = 0; ready_a = 0; ovr_clr_a = 0; end
    else        begin rst_n_b = 0; ce_b = 0; ready_b = 0; ovr_clr_b = 0; end
    @(negedge clk);
    if (d == 0) rst_n_a = 1; else rst_n_b = 1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int first;
    rst_n_a = 0; ce_a = 0; sdin_a = '0; ready_a = 0; ovr_clr_a = 0;
    rst_n_b = 0; ce_b = 0; sdin_b = '0; ready_b = 0; ovr_clr_b = 0;
    build_h(0);
    build_h(1);
    repeat (3) @(negedge clk);
    check_eq("rst_a_dout", {8'd0, dout_a}, 32'd0);
    check_eq("rst_a_valid", {31'd0, valid_a}, 32'd0);

    // Full scale positive on both channels: saturation path.
    do_reset(0);
    drive(0, 6 * RA, 1, 1, 1, 1);
    settle();
    check_eq("sat_ch0", {20'd0, dout_a[11:0]}, 32'hFFF);
    check_eq("sat_ch1", {20'd0, dout_a[23:12]}, 32'hFFF);
    check_eq("sat_fb", {30'd0, fb_a}, 32'd0);

    // Zero input.
    do_reset(0);
    drive(0, 6 * RA, 1, 0, 0, 1);
    settle();
    check_eq("zero_ch0", {20'd0, dout_a[11:0]}, 32'h000);
    check_eq("zero_ch1", {20'd0, dout_a[23:12]}, 32'h000);
    check_eq("zero_fb", {30'd0, fb_a}, 32'd3);

    // Half scale on ch0, full scale on ch1: channel independence.
    do_reset(0);
    drive(0, 6 * RA, 1, 2, 1, 1);
    settle();
    check_eq("half_ch0", {20'd0, dout_a[11:0]}, 32'h800);
    check_eq("half_ch1", {20'd0, dout_a[23:12]}, 32'hFFF);

    // Slow ce, consumer stalled over two commits.
    do_reset(0);
    drive(0, 2 * RA * 4, 4, 1, 2, 0);
    settle();
    check_eq("ovr_set", {31'd0, overrun_a}, 32'd1);
    check_eq("ovr_valid", {31'd0, valid_a}, 32'd1);
    check_eq("ovr_newest0", {20'd0, dout_a[11:0]}, dexp[0]);
    @(negedge clk); ce_a = 0; ovr_clr_a = 1;
    @(negedge clk); ovr_clr_a = 0;
    check_eq("ovr_clr", {31'd0, overrun_a}, 32'd0);
    ready_a = 1;
    @(negedge clk); ready_a = 0;
    check_eq("accept_valid", {31'd0, valid_a}, 32'd0);

    // Ready only on commit ticks: valid stays high, no overrun.
    do_reset(0);
    drive(0, 3 * RA + 8, 1, 2, 1, 3);
    settle();
    check_eq("same_cyc_valid", {31'd0, valid_a}, 32'd1);
    check_eq("same_cyc_ovr", {31'd0, overrun_a}, 32'd0);

    // Reset mid-frame, then time the first commit.
    drive(0, 30, 1, 1, 0, 1);
    @(negedge clk); rst_n_a = 0; ce_a = 1;
    @(negedge clk);
    check_eq("mid_rst_fb", {30'd0, fb_a}, 32'd0);
    check_eq("mid_rst_dout", {8'd0, dout_a}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    check_eq("mid_rst_ovr", {31'd0, overrun_a}, 32'd0);
    rst_n_a = 1; ce_a = 1; ready_a = 0;
    first = -1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (newsample_a) begin first = k; break; end
      @(negedge clk);
    end
    check_eq("first_commit_tick", first, RA - 1);

    // Randomized traffic on instance a.
    do_reset(0);
    drive(0, 3000, 0, 3, 3, 2);
    @(negedge clk); ce_a = 0; ready_a = 0; ovr_clr_a = 0;

    // Instance b: order 2, R = 32, 10-bit output.
    do_reset(1);
    drive(1, 5 * RB, 1, 1, 0, 1);
    settle();
    check_eq("b_sat", {22'd0, dout_b}, 32'h3FF);
    do_reset(1);
    drive(1, 5 * RB, 1, 2, 0, 1);
    settle();
    check_eq("b_half", {22'd0, dout_b}, 32'h200);
    do_reset(1);
    drive(1, 2000, 0, 3, 0, 2);
    @(negedge clk); ce_b = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sd_adc_cic.md
Name: sd_adc_cic

Overview:
Multi-channel sigma-delta ADC front end: closes the comparator/integrator feedback loop per channel and decimates the 1-bit stream with a parametrised CIC filter (order, decimation ratio and output width selectable). It is the successor of the single-channel fixed 3rd-order/R=64 converter. Outputs are registered words with a valid/ready handshake and overrun detection, for audio/tape-in capture feeding the soft-core bus.

Parameters:
NCH, 2, number of independent channels (1..8)
ORDER, 3, CIC order (1..4)
LOG2R, 6, log2 of decimation ratio R (4..8)
OW, 12, output word width; must satisfy OW <= ORDER*LOG2R
Derived: W = ORDER*LOG2R + 1, integrator/comb width (19 at defaults)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
ce  in  1  modulator tick (clk/R*Fs); all filter state advances only when ce=1
sdin  in  NCH  comparator outputs, one bit per channel
fb  out  NCH  feedback to integrators, registered
dout  out  NCH*OW  channel c occupies [c*OW +: OW]
valid  out  1  dout holds an unread sample set
ready  in  1  consumer accepts dout when valid&&ready
newsample  out  1  one-clk pulse coincident with the ce tick that commits a new sample set
overrun  out  1  sticky: a sample set was overwritten before being accepted
ovr_clr  in  1  clears overrun

Behaviour:
- Reset (rst_n=0 at clk edge): fb, all integrators, combs, decimation counter, dout, valid, overrun := 0. Takes priority over every other event.
- Per channel on ce=1: fb[c] <= ~sdin[c]; integrator input x = ~fb[c] (1 bit, zero-extended to W), i.e. sdin delayed one tick.
- Integrator chain, ORDER stages, modulo 2^W: add1 = x + I1, addk = add(k-1) + Ik; Ik <= addk every ce.
- Decimation counter LOG2R bits, increments on ce, wraps. newsample = ce && counter all-ones (one tick every R ce ticks).
- Comb chain on newsample: sub1 = addORDER - D1, subk = sub(k-1) - Dk; D1 <= addORDER, Dk <= sub(k-1). Modulo 2^W arithmetic.
- Output mapping: if subORDER[W-1]=1 -> all ones (saturation, covers exact full scale 2^(W-1)); else subORDER[W-2 : W-1-OW].
- All NCH channels commit dout on the same newsample tick.
- ce=0: filter state, fb, counter frozen; handshake still operates.
- Handshake: valid <= 1 on commit. valid&&ready with no commit -> valid <= 0. Commit and accept in same cycle -> valid stays 1, new data, no overrun.
- Commit while valid=1 and ready=0 -> dout overwritten, overrun <= 1. overrun cleared by ovr_clr unless a new overrun occurs in the same cycle (set wins).
- dout stable while valid=1 except at a commit.
- Latency: first commit after R ce ticks from reset; output settles to steady state from the (ORDER+1)th commit onward.
- Channels fully independent; sdin of one channel never affects another.

Test Plan:
- Defaults, ce=1 every clk, sdin=2'b11 constant, ready=1 -> fb=0; from 4th commit dout ch0=ch1=12'hFFF (saturation path).
- sdin=2'b00 constant -> fb=2'b11; from 4th commit both channels 12'h000.
- ch0 sdin toggles each ce, ch1 held 1 -> steady ch0=12'h800, ch1=12'hFFF; checks channel independence.
- ce=1 every 4th clk, ready held 0 for two commits -> overrun=1 after second commit, dout = newest data; ovr_clr pulse -> overrun=0; ready pulse -> valid=0.
- ready=1 exactly on commit cycle with valid=1 -> valid stays 1, overrun stays 0; rst_n=0 mid-frame -> next edge all outputs 0, first commit again R ticks later.
- ORDER=2, LOG2R=5, OW=10, NCH=1: sdin constant 1 -> 10'h3FF; toggling -> 10'h200 from 3rd commit.
